// File: rtl/sdr_pkg.sv
// Shared definitions for the 16-bit SDR SDRAM controller: command pin encodings,
// LMR CAS-latency field values and the read-return latency helper.
package sdr_pkg;

  // Pin encoding {cs_n, ras_n, cas_n, we_n}
  typedef enum logic [3:0] {
    CMD_LMR   = 4'b0000,
    CMD_REF   = 4'b0001,
    CMD_PRE   = 4'b0010,
    CMD_ACT   = 4'b0011,
    CMD_WRITE = 4'b0100,
    CMD_READ  = 4'b0101,
    CMD_BST   = 4'b0110,
    CMD_NOP   = 4'b0111
  } sdr_cmd_e;

  localparam logic [1:0] LMR_CL2 = 2'b10;
  localparam logic [1:0] LMR_CL3 = 2'b11;

  function automatic int cl_from_lmr(input logic [1:0] field);
    return (field == LMR_CL3) ? 3 : 2;
  endfunction

  function automatic logic [1:0] lmr_from_cl(input int cl);
    return (cl == 3) ? LMR_CL3 : LMR_CL2;
  endfunction

  // Cycles from the READ command to beat0 arriving after the input alignment stages
  function automatic int rd_lat(input int cl, input int in_dly);
    return cl + in_dly;
  endfunction

endpackage

// File: rtl/sdr_dly_line.sv
// Free-running shift register: o_dat is i_dat delayed by DEPTH clocks, DEPTH 0 is a plain wire.
// Synchronous clear; no flow control, the line advances every cycle.
module sdr_dly_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Clock and clear have nothing to drive when the line collapses to a wire
      logic w_unused;
      assign w_unused = i_clk ^ i_rst;
      assign o_dat    = i_dat;
    end else begin : g_reg
      logic [W-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= i_dat;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_dat = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sdr_16_rd_capture.sv
// Read-data return path: tracks READ commands through a valid pipeline and packs each BL=2 burst
// into one {beat0,beat1} word, strobed CL+IN_DLY+2 cycles after the command; never stalls.
module sdr_16_rd_capture
  import sdr_pkg::*;
#(
  parameter int CL     = 2,
  parameter int IN_DLY = 0,
  parameter int DW     = 16
) (
  input  logic            sdram_clk,
  input  logic            sdram_rst,
  input  logic            cmd_read,
  input  logic [DW-1:0]   dq_i,
  input  logic            fifo_full,
  input  logic            ovf_clr,
  output logic [2*DW-1:0] data_o,
  output logic            data_we,
  output logic            rd_busy,
  output logic            ovf,
  output logic            proto_err
);

  localparam int LAT = rd_lat(CL, IN_DLY);

  logic            w_cmd;
  logic [DW-1:0]   w_dq;
  logic [LAT:0]    w_vsr_q;
  logic [LAT+1:0]  w_vsr;

  logic [DW-1:0]   r_beat0;
  logic [2*DW-1:0] r_data;
  logic            r_we;
  logic            r_ovf;
  logic            r_perr;

  assign w_cmd = cmd_read & ~sdram_rst;

  sdr_dly_line #(
    .W     (DW),
    .DEPTH (IN_DLY)
  ) u_dq_dly (
    .i_clk (sdram_clk),
    .i_rst (sdram_rst),
    .i_dat (dq_i),
    .o_dat (w_dq)
  );

  // vsr[0] is the live command; vsr[LAT+1:1] is one register rank loaded with vsr shifted up.
  // Bit k is therefore set k cycles after the READ, lining up with dq after the IN_DLY stages.
  sdr_dly_line #(
    .W     (LAT+1),
    .DEPTH (1)
  ) u_vsr (
    .i_clk (sdram_clk),
    .i_rst (sdram_rst),
    .i_dat ({w_vsr_q[LAT-1:0], w_cmd}),
    .o_dat (w_vsr_q)
  );

  assign w_vsr = {w_vsr_q, w_cmd};

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      r_beat0 <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_ovf   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (w_vsr[LAT]) r_beat0 <= w_dq;
      if (w_vsr[LAT+1]) r_data <= {r_beat0, w_dq};
      r_we <= w_vsr[LAT+1];

      // Set beats clear: an event in the clearing cycle must not be lost
      if (r_we && fifo_full) r_ovf <= 1'b1;
      else if (ovf_clr)      r_ovf <= 1'b0;

      if (w_cmd && w_vsr[1]) r_perr <= 1'b1;
      else if (ovf_clr)      r_perr <= 1'b0;
    end
  end

  assign data_o    = r_data;
  assign data_we   = r_we;
  assign rd_busy   = (|w_vsr[LAT+1:1]) | r_we;
  assign ovf       = r_ovf;
  assign proto_err = r_perr;

endmodule
